// File: rtl/serial_deser.sv
// Framed serial receiver: start bit (1), DATA_W data bits, optional even parity, stop bit (0).
// Optional parity stage is enabled by defining SER_PARITY_EN.
module serial_deser #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd3} state_t;
`endif

  state_t            state_p0, nxt_p0;
  logic [CW-1:0]     cnt_p0;
  logic [DATA_W-1:0] sr_p0;
  logic              vld_p0, ferr_p0;
`ifdef SER_PARITY_EN
  logic              par_bad_p0, perr_p0;
`endif

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] s, input logic b);
    if (MSB_FIRST) return {s[DATA_W-2:0], b};
    else           return {b, s[DATA_W-1:1]};
  endfunction

`ifdef SER_PARITY_EN
  function automatic logic even_par(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_p0 <= IDLE;
    else        state_p0 <= nxt_p0;
  end

  always_comb begin
    nxt_p0 = state_p0;
    if (en) begin
      case (state_p0)
        IDLE:    if (din) nxt_p0 = DATA;
`ifdef SER_PARITY_EN
        DATA:    if (cnt_p0 == LAST) nxt_p0 = PARITY;
        PARITY:  nxt_p0 = STOP;
`else
        DATA:    if (cnt_p0 == LAST) nxt_p0 = STOP;
`endif
        STOP:    nxt_p0 = IDLE;
        default: nxt_p0 = IDLE;
      endcase
    end
  end

  // Frame verdict is decided on the enabled sample of the stop bit
  always_comb begin
    vld_p0  = 1'b0;
    ferr_p0 = 1'b0;
`ifdef SER_PARITY_EN
    perr_p0 = 1'b0;
`endif
    if (en && state_p0 == STOP) begin
      ferr_p0 = din;
`ifdef SER_PARITY_EN
      perr_p0 = par_bad_p0;
      vld_p0  = !din && !par_bad_p0;
`else
      vld_p0  = !din;
`endif
    end
  end

  assign busy = (state_p0 != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p0     <= '0;
      sr_p0      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SER_PARITY_EN
      par_bad_p0 <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      dout_valid <= vld_p0;
      frame_err  <= ferr_p0;
`ifdef SER_PARITY_EN
      parity_err <= perr_p0;
`endif
      if (vld_p0) dout <= sr_p0;
      if (en) begin
        case (state_p0)
          IDLE: begin
            cnt_p0 <= '0;
`ifdef SER_PARITY_EN
            par_bad_p0 <= 1'b0;
`endif
          end
          DATA: begin
            sr_p0 <= shift_in(sr_p0, din);
            if (cnt_p0 != LAST) cnt_p0 <= cnt_p0 + CW'(1);
          end
`ifdef SER_PARITY_EN
          PARITY: par_bad_p0 <= (din != even_par(sr_p0));
`endif
          STOP:    cnt_p0 <= '0;
          default: ;
        endcase
      end
    end
  end

`ifndef SER_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Randomized bench for serial_deser; frames are built from the word, stop and parity rules
// and the expected verdict comes from those rules directly.
module tb_serial_deser;
  localparam int DATA_W    = 8;
  localparam bit MSB_FIRST = 1'b0;

  logic              clk = 1'b0;
  logic              rst_n, din, en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid, busy, frame_err, parity_err;
  int                checks = 0;
  int                errors = 0;
  logic [DATA_W-1:0] exp_dout;

  always #5 clk = ~clk;

  serial_deser #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .frame_err(frame_err), .parity_err(parity_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame with gap_lo..gap_hi disabled cycles before each bit, returns the
  // outputs seen right after the stop sample and a count of anomalies seen before it.
  task automatic send_frame(input logic [DATA_W-1:0] word, input logic stop, input logic pflip,
                            input int gap_lo, input int gap_hi,
                            output logic v, output logic fe, output logic pe,
                            output logic [DATA_W-1:0] d, output logic b, output int spur);
    logic bits[$];
    bits = {};
    spur = 0;
    bits.push_back(1'b1);
    for (int i = 0; i < DATA_W; i++)
      bits.push_back(MSB_FIRST ? word[DATA_W-1-i] : word[i]);
`ifdef SER_PARITY_EN
    bits.push_back(1'(($countones(word) % 2)) ^ pflip);
`else
    if (pflip) spur = spur + 0;
`endif
    bits.push_back(stop);
    for (int i = 0; i < bits.size(); i++) begin
      repeat ($urandom_range(gap_hi, gap_lo)) begin
        en = 1'b0; din = 1'($urandom_range(1, 0));
        tick();
        if (dout_valid || frame_err || parity_err || dout !== exp_dout) spur++;
      end
      en = 1'b1; din = bits[i];
      tick();
      if (i != bits.size() - 1)
        if (dout_valid || frame_err || parity_err || busy !== 1'b1 || dout !== exp_dout) spur++;
    end
    v = dout_valid; fe = frame_err; pe = parity_err; d = dout; b = busy;
    en = 1'b0; din = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = 1'b1; en = 1'b1;
    tick(); tick();
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_err !== 1'b0 || parity_err !== 1'b0) begin
      errors++; $display("FAIL reset_errs got %b%b want 00", frame_err, parity_err); end
    rst_n = 1'b1; din = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b want 0", busy); end
    exp_dout = '0;
  endtask

  task automatic test_good_frame();
    logic v, fe, pe, b; logic [DATA_W-1:0] d; int spur;
    send_frame(8'hA5, 1'b0, 1'b0, 0, 0, v, fe, pe, d, b, spur);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL good_valid got %b want 1", v); end
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL good_dout got %h want a5", d); end
    checks++; if (fe !== 1'b0 || pe !== 1'b0) begin errors++; $display("FAIL good_errs got %b%b want 00", fe, pe); end
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL good_busy got %b want 0", b); end
    checks++; if (spur != 0) begin errors++; $display("FAIL good_midframe got %0d anomalies want 0", spur); end
    exp_dout = 8'hA5;
    en = 1'b1; din = 1'b0;
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL good_pulse_width got %b want 0", dout_valid); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL good_hold got %h want a5", dout); end
  endtask

  task automatic test_bad_stop();
    logic v, fe, pe, b; logic [DATA_W-1:0] d; int spur;
    send_frame(8'hA5 ^ 8'hFF, 1'b1, 1'b0, 0, 0, v, fe, pe, d, b, spur);
    checks++; if (fe !== 1'b1) begin errors++; $display("FAIL badstop_ferr got %b want 1", fe); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL badstop_valid got %b want 0", v); end
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL badstop_dout got %h want a5", d); end
    checks++; if (b !== 1'b0 || spur != 0) begin
      errors++; $display("FAIL badstop_busy_mid got busy %b anomalies %0d want 0 0", b, spur); end
    en = 1'b1; din = 1'b0;
    tick();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL badstop_pulse_width got %b want 0", frame_err); end
  endtask

  task automatic test_en_gating();
    logic v, fe, pe, b; logic [DATA_W-1:0] d; int spur;
    exp_dout = 8'h00;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0, 1, 1, v, fe, pe, d, b, spur);
    checks++; if (v !== 1'b1 || d !== 8'hA5) begin
      errors++; $display("FAIL engate_result got valid %b dout %h want 1 a5", v, d); end
    checks++; if (spur != 0) begin errors++; $display("FAIL engate_hold got %0d anomalies want 0", spur); end
    exp_dout = 8'hA5;
    en = 1'b0; din = 1'b1;
    tick();
    checks++; if (dout_valid !== 1'b0 || dout !== 8'hA5 || busy !== 1'b0) begin
      errors++; $display("FAIL engate_after got valid %b dout %h busy %b want 0 a5 0", dout_valid, dout, busy); end
  endtask

  task automatic test_reset_mid();
    logic v, fe, pe, b; logic [DATA_W-1:0] d; int spur; int pulses;
    en = 1'b1; din = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin din = 1'($urandom_range(1, 0)); tick(); end
    rst_n = 1'b0; din = 1'b1;
    tick();
    rst_n = 1'b1;
    checks++; if (dout_valid || frame_err || parity_err || busy || dout !== '0) begin
      errors++; $display("FAIL midreset_state got v%b fe%b pe%b busy%b dout %h want all 0",
                         dout_valid, frame_err, parity_err, busy, dout); end
    exp_dout = '0;
    send_frame(8'h3C, 1'b0, 1'b0, 0, 0, v, fe, pe, d, b, spur);
    checks++; if (v !== 1'b1 || d !== 8'h3C || spur != 0) begin
      errors++; $display("FAIL midreset_frame got v %b dout %h anomalies %0d want 1 3c 0", v, d, spur); end
    exp_dout = 8'h3C;
    pulses = 0;
    en = 1'b1; din = 1'b0;
    repeat (6) begin tick(); if (dout_valid) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midreset_once got %0d extra pulses want 0", pulses); end
  endtask

`ifdef SER_PARITY_EN
  task automatic test_parity();
    logic v, fe, pe, b; logic [DATA_W-1:0] d; int spur;
    send_frame(8'hA5, 1'b0, 1'b0, 0, 0, v, fe, pe, d, b, spur);
    checks++; if (v !== 1'b1 || pe !== 1'b0 || d !== 8'hA5) begin
      errors++; $display("FAIL parity_ok got v %b pe %b dout %h want 1 0 a5", v, pe, d); end
    exp_dout = 8'hA5;
    send_frame(8'h5A, 1'b0, 1'b1, 0, 0, v, fe, pe, d, b, spur);
    checks++; if (pe !== 1'b1 || v !== 1'b0 || fe !== 1'b0 || d !== 8'hA5) begin
      errors++; $display("FAIL parity_bad got pe %b v %b fe %b dout %h want 1 0 0 a5", pe, v, fe, d); end
    send_frame(8'h0F, 1'b1, 1'b1, 0, 0, v, fe, pe, d, b, spur);
    checks++; if (pe !== 1'b1 || fe !== 1'b1 || v !== 1'b0) begin
      errors++; $display("FAIL parity_both got pe %b fe %b v %b want 1 1 0", pe, fe, v); end
  endtask
`endif

  task automatic test_back_to_back();
    logic v, fe, pe, b; logic [DATA_W-1:0] d; int spur;
    logic [DATA_W-1:0] w; logic stop, pflip, ev, efe, epe;
    for (int n = 0; n < 24; n++) begin
      w     = DATA_W'($urandom);
      stop  = ($urandom_range(3, 0) == 0);
      pflip = ($urandom_range(3, 0) == 0);
`ifdef SER_PARITY_EN
      epe = pflip;
`else
      epe = 1'b0;
`endif
      efe = stop;
      ev  = !stop && !epe;
      send_frame(w, stop, pflip, 0, (n % 3 == 0) ? 0 : 2, v, fe, pe, d, b, spur);
      if (ev) exp_dout = w;
      checks++; if (v !== ev || fe !== efe || pe !== epe) begin
        errors++; $display("FAIL b2b_flags[%0d] got v%b fe%b pe%b want v%b fe%b pe%b", n, v, fe, pe, ev, efe, epe); end
      checks++; if (d !== exp_dout || b !== 1'b0) begin
        errors++; $display("FAIL b2b_dout[%0d] got %h busy %b want %h 0", n, d, b, exp_dout); end
      checks++; if (spur != 0) begin errors++; $display("FAIL b2b_mid[%0d] got %0d anomalies want 0", n, spur); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    exp_dout = '0;
    test_reset();
    test_good_frame();
    test_bad_stop();
    test_en_gating();
    test_reset_mid();
`ifdef SER_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
